// File: rtl/sdram_arbiter_if.sv
// Command-bus handshake between the SDRAM arbiter and its refresh/write/read
// sub-controllers, plus status outputs.
interface sdram_arbiter_if;
    logic       init_done;
    logic       wr_req;
    logic       rd_req;
    logic       ref_done;
    logic       wr_done;
    logic       rd_done;
    logic       ref_en;
    logic       wr_en;
    logic       rd_en;
    logic       busy;
    logic [2:0] arb_state;
    logic       ref_overrun;

    modport slave (
        input  init_done, wr_req, rd_req, ref_done, wr_done, rd_done,
        output ref_en, wr_en, rd_en, busy, arb_state, ref_overrun
    );

    modport master (
        output init_done, wr_req, rd_req, ref_done, wr_done, rd_done,
        input  ref_en, wr_en, rd_en, busy, arb_state, ref_overrun
    );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: refresh has priority, write/read share the bus
// round-robin, grants run until the matching done pulse.
module sdram_arbiter #(
    parameter int REF_PERIOD = 780,
    parameter int CNT_W      = 10
) (
    input  logic            clk,
    input  logic            rst,
    sdram_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARB   = 3'd1,
        S_REF   = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(REF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic             r_ref_pending;
    logic             r_ref_overrun;
    logic             r_last_wr;
    logic             r_ref_en;
    logic             r_wr_en;
    logic             r_rd_en;
    logic             r_busy;
    logic             w_tc;
    logic             w_enter_ref;

    assign w_tc        = (r_state != S_INIT) && (r_timer == TERM_CNT);
    assign w_enter_ref = (r_state == S_ARB) && (w_next == S_REF);

    // Next-state selection: refresh first, then the requester not granted last.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: begin
                if (bus.init_done) w_next = S_ARB;
                else               w_next = S_INIT;
            end
            S_ARB: begin
                if (r_ref_pending)                 w_next = S_REF;
                else if (bus.wr_req && bus.rd_req) w_next = r_last_wr ? S_READ : S_WRITE;
                else if (bus.wr_req)               w_next = S_WRITE;
                else if (bus.rd_req)               w_next = S_READ;
                else                               w_next = S_ARB;
            end
            S_REF: begin
                if (bus.ref_done) w_next = S_ARB;
                else              w_next = S_REF;
            end
            S_WRITE: begin
                if (bus.wr_done) w_next = S_ARB;
                else             w_next = S_WRITE;
            end
            S_READ: begin
                if (bus.rd_done) w_next = S_ARB;
                else             w_next = S_READ;
            end
            default: w_next = S_ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_next;
    end

    // Refresh interval timer, frozen at zero until initialisation completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_timer <= '0;
        else if (r_state == S_INIT)    r_timer <= '0;
        else if (r_timer == TERM_CNT)  r_timer <= '0;
        else                           r_timer <= r_timer + CNT_ONE;
    end

    // Pending refresh and sticky overrun; a new deadline beats the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_pending <= 1'b0;
            r_ref_overrun <= 1'b0;
        end else if (w_tc) begin
            r_ref_pending <= 1'b1;
            r_ref_overrun <= r_ref_overrun | r_ref_pending;
        end else if (w_enter_ref) begin
            r_ref_pending <= 1'b0;
            r_ref_overrun <= r_ref_overrun;
        end else begin
            r_ref_pending <= r_ref_pending;
            r_ref_overrun <= r_ref_overrun;
        end
    end

    // Round-robin memory: 1 means write was granted most recently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       r_last_wr <= 1'b0;
        else if (r_state == S_ARB && w_next == S_WRITE) r_last_wr <= 1'b1;
        else if (r_state == S_ARB && w_next == S_READ)  r_last_wr <= 1'b0;
        else                                           r_last_wr <= r_last_wr;
    end

    // Registered enables and busy, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_en <= 1'b0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ref_en <= (w_next == S_REF);
            r_wr_en  <= (w_next == S_WRITE);
            r_rd_en  <= (w_next == S_READ);
            r_busy   <= (w_next != S_ARB);
        end
    end

    assign bus.ref_en      = r_ref_en;
    assign bus.wr_en       = r_wr_en;
    assign bus.rd_en       = r_rd_en;
    assign bus.busy        = r_busy;
    assign bus.arb_state   = r_state;
    assign bus.ref_overrun = r_ref_overrun;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a reference model predicts enable
// changes into a queue that a negedge monitor pops and compares.
module tb_sdram_arbiter;
    localparam int P = 16;

    logic clk;
    logic rst;
    sdram_arbiter_if bus();

    sdram_arbiter #(.REF_PERIOD(P), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 init, 1 idle, 2 refresh, 3 write, 4 read
    int         m_mode;
    int         m_age;
    bit         m_pend, m_ovr, m_last_wr, m_busy;
    logic [2:0] m_en;
    logic [2:0] exp_en_q[$];
    time        exp_t_q[$];

    bit         mon_on = 1'b0;
    logic [2:0] mon_obs;
    logic [2:0] mon_last = 3'b000;
    time        mon_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic [2:0] en);
        if (en != m_en) begin
            exp_en_q.push_back(en);
            exp_t_q.push_back($time);
        end
        m_en = en;
    endtask

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_pend = 1'b0; m_ovr = 1'b0;
        m_last_wr = 1'b0; m_busy = 1'b0;
        model_push(3'b000);
    endtask

    task automatic model_step();
        int nxt;
        bit deadline;
        if (rst) begin
            model_reset();
            return;
        end
        deadline = (m_mode != 0) && ((m_age % P) == P - 1);
        nxt = m_mode;
        if (m_mode == 0)      nxt = bus.init_done ? 1 : 0;
        else if (m_mode == 1) begin
            if (m_pend)                          nxt = 2;
            else if (bus.wr_req && bus.rd_req)   nxt = m_last_wr ? 4 : 3;
            else if (bus.wr_req)                 nxt = 3;
            else if (bus.rd_req)                 nxt = 4;
        end
        else if (m_mode == 2 && bus.ref_done)   nxt = 1;
        else if (m_mode == 3 && bus.wr_done)    nxt = 1;
        else if (m_mode == 4 && bus.rd_done)    nxt = 1;
        if (m_mode == 1 && nxt == 3) m_last_wr = 1'b1;
        if (m_mode == 1 && nxt == 4) m_last_wr = 1'b0;
        if (deadline) begin
            if (m_pend) m_ovr = 1'b1;
            m_pend = 1'b1;
        end else if (m_mode == 1 && nxt == 2) begin
            m_pend = 1'b0;
        end
        m_age  = (m_mode == 0) ? 0 : m_age + 1;
        m_mode = nxt;
        m_busy = (nxt != 1);
        model_push({nxt == 2, nxt == 3, nxt == 4});
    endtask

    // Monitor: per-cycle status checks and scoreboard pop on enable changes.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_obs = {bus.ref_en, bus.wr_en, bus.rd_en};
            check("enable_onehot", ($countones(mon_obs) <= 1) ? 1 : 0, 1);
            check("arb_state", bus.arb_state, m_mode);
            check("busy", bus.busy, m_busy);
            check("ref_overrun", bus.ref_overrun, m_ovr);
            if (mon_obs !== mon_last) begin
                if (exp_en_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_enable_change: got %b expected %b at %0t",
                             mon_obs, mon_last, $time);
                end else begin
                    mon_t = exp_t_q.pop_front();
                    check("enable_vector", mon_obs, exp_en_q.pop_front());
                    check("enable_timing", (($time > mon_t) && ($time - mon_t <= 5)) ? 1 : 0, 1);
                end
            end
            mon_last = mon_obs;
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus.ref_done = 1'b0;
        bus.wr_done  = 1'b0;
        bus.rd_done  = 1'b0;
    endtask

    task automatic pulse_done();
        if (m_mode == 2)      bus.ref_done = 1'b1;
        else if (m_mode == 3) bus.wr_done  = 1'b1;
        else if (m_mode == 4) bus.rd_done  = 1'b1;
    endtask

    task automatic wait_grant(output int kind, output int n);
        n = 0;
        while (m_mode < 2 && n < 60) begin
            tick();
            n++;
        end
        check("grant_timeout", (n < 60) ? 1 : 0, 1);
        kind = int'(bus.arb_state);
    endtask

    task automatic finish_op(input int lat);
        repeat (lat) tick();
        pulse_done();
        tick();
    endtask

    task automatic next_data_op(output int kind);
        int n;
        for (int i = 0; i < 4; i++) begin
            wait_grant(kind, n);
            if (m_mode == 2) finish_op(1);
            else break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k, n, lat, g, d;
        rst = 1'b1;
        bus.init_done = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.ref_done = 1'b0; bus.wr_done = 1'b0; bus.rd_done = 1'b0;
        model_reset();
        repeat (2) tick();
        mon_on = 1'b1;
        tick();
        check("reset_outputs", {bus.ref_en, bus.wr_en, bus.rd_en, bus.busy,
                                bus.ref_overrun, bus.arb_state}, 0);

        // Power-up: stay in INIT until init_done
        rst = 1'b0;
        repeat (20) tick();
        check("init_hold_state", bus.arb_state, 0);
        check("init_hold_busy", bus.busy, 1);
        bus.init_done = 1'b1;
        tick();
        check("init_to_arb", bus.arb_state, 1);
        check("arb_not_busy", bus.busy, 0);
        bus.init_done = 1'b0;

        // Round robin with both requests held; first tie goes to write
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_data_op(k);
            check("rr_order", k, (i % 2 == 0) ? 3 : 4);
            finish_op(1 + i % 3);
        end

        // Refresh pending during a write is served before the waiting read
        bus.rd_req = 1'b0;
        next_data_op(k);
        check("lone_write", k, 3);
        bus.wr_req = 1'b0; bus.rd_req = 1'b1;
        n = 0;
        while (!m_pend && n < 40) begin tick(); n++; end
        check("pending_timeout", (n < 40) ? 1 : 0, 1);
        repeat (10) tick();
        bus.wr_done = 1'b1;
        tick();
        wait_grant(k, n);
        check("ref_before_read", k, 2);
        check("ref_latency", n, 1);
        finish_op(1);
        wait_grant(k, n);
        check("read_after_ref", k, 4);
        bus.rd_req = 1'b0;
        finish_op(1);

        // Write held past two deadlines sets the sticky overrun
        bus.wr_req = 1'b1;
        next_data_op(k);
        bus.wr_req = 1'b0;
        repeat (40) tick();
        check("overrun_set", bus.ref_overrun, 1);
        finish_op(0);
        wait_grant(k, n);
        finish_op(1);
        check("overrun_sticky", bus.ref_overrun, 1);

        // Non-matching done pulses are ignored
        bus.wr_req = 1'b1;
        next_data_op(k);
        bus.wr_req = 1'b0;
        tick();
        bus.rd_done = 1'b1; bus.ref_done = 1'b1;
        tick();
        check("spurious_done_state", bus.arb_state, 3);
        check("spurious_done_en", {bus.ref_en, bus.wr_en, bus.rd_en}, 3'b010);
        finish_op(1);
        if (m_pend) begin
            wait_grant(k, n);
            finish_op(1);
        end
        if (!m_pend && m_mode == 1) begin
            bus.ref_done = 1'b1; bus.wr_done = 1'b1;
            tick();
            check("arb_done_state", bus.arb_state, 1);
            check("arb_done_en", {bus.ref_en, bus.wr_en, bus.rd_en}, 3'b000);
        end

        // Reset mid-write drops the enable immediately
        bus.wr_req = 1'b1;
        next_data_op(k);
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_wr_en", bus.wr_en, 0);
        check("async_reset_outputs", {bus.ref_en, bus.wr_en, bus.rd_en, bus.busy,
                                      bus.ref_overrun}, 0);
        tick();
        rst = 1'b0; bus.wr_req = 1'b0;
        tick();
        check("restart_init", bus.arb_state, 0);
        check("overrun_cleared", bus.ref_overrun, 0);
        bus.init_done = 1'b1;
        tick();

        // Randomised traffic with spurious done pulses
        lat = -1;
        repeat (2500) begin
            bus.init_done = 1'($urandom_range(0, 1));
            if (m_mode >= 2) begin
                if (lat < 0) begin
                    lat = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 35)
                                                      : $urandom_range(0, 6);
                    if (m_mode == 3 && $urandom_range(0, 1) == 1) bus.wr_req = 1'b0;
                    if (m_mode == 4 && $urandom_range(0, 1) == 1) bus.rd_req = 1'b0;
                end else if (lat == 0) begin
                    pulse_done();
                    lat = -1;
                end else begin
                    lat--;
                end
            end
            if (!bus.wr_req && $urandom_range(0, 3) == 0) bus.wr_req = 1'b1;
            if (!bus.rd_req && $urandom_range(0, 3) == 0) bus.rd_req = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                d = $urandom_range(0, 2);
                if (d + 2 != m_mode) begin
                    if (d == 0)      bus.ref_done = 1'b1;
                    else if (d == 1) bus.wr_done  = 1'b1;
                    else             bus.rd_done  = 1'b1;
                end
            end
            tick();
        end

        // Drain and confirm every predicted change was observed
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        g = 0;
        while (m_mode != 1 && g < 100) begin
            if (m_mode >= 2) finish_op(0);
            else tick();
            g++;
        end
        tick();
        #6;
        check("scoreboard_drained", exp_en_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
